blink_meter: RTL and testbench

- Input-side counterpart of the board's LED blinker divider.
- Takes an asynchronous square-wave input from a blinker output, another board or a test pin, and synchronizes it to clk.
- Measures the high time and full period in clk cycles, and reports each completed period with a one-cycle valid strobe.
- Used on the lab board to check blinker outputs and to drive status LEDs.

---
 rtl/blink_pkg.sv | 14 +
 rtl/sig_cond.sv | 67 ++++++
 rtl/blink_meter.sv | 130 +++++++++++++
 tb/tb_blink_meter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/blink_pkg.sv
// Shared types and defaults for the blink_meter input-side measurement block.
package blink_pkg;

  localparam int                     CLK_HZ      = 125000000;
  localparam int                     CNT_W_DEF   = 28;
  localparam logic [CNT_W_DEF-1:0]   TIMEOUT_DEF = 28'd250000000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

endpackage

// File: rtl/sig_cond.sv
// Input conditioning: synchronizer, optional glitch filter (BLINK_METER_FILTER_EN)
// and rise/fall detector on the conditioned level.
module sig_cond
  import blink_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4
) (
  input  logic clk,
  input  logic rst_n_i,
  input  logic sig_i,
  output logic s_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   cond;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_i};
    end
  end

`ifdef BLINK_METER_FILTER_EN
  localparam int RUN_W = $clog2(FILT_LEN + 1);

  logic [RUN_W-1:0] run_q;
  logic             filt_q;

  // Output flips only once the synchronized level has disagreed for FILT_LEN samples in a row.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      run_q  <= '0;
      filt_q <= 1'b0;
    end else if (sync_q[SYNC_STAGES-1] == filt_q) begin
      run_q <= '0;
    end else if (run_q == RUN_W'(FILT_LEN - 1)) begin
      run_q  <= '0;
      filt_q <= sync_q[SYNC_STAGES-1];
    end else begin
      run_q <= run_q + RUN_W'(1);
    end
  end

  assign cond = filt_q;
`else
  assign cond = sync_q[SYNC_STAGES-1];
`endif

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= cond;
    end
  end

  assign s_o    = cond;
  assign rise_o = cond & ~prev_q;
  assign fall_o = ~cond & prev_q;

endmodule

// File: rtl/blink_meter.sv
// Measures high time and period of an asynchronous square wave in clk cycles.
// Optional glitch filter enabled by defining BLINK_METER_FILTER_EN.
module blink_meter
  import blink_pkg::*;
#(
  parameter int               CNT_W       = CNT_W_DEF,
  parameter logic [CNT_W-1:0] TIMEOUT     = CNT_W'(TIMEOUT_DEF),
  parameter int               SYNC_STAGES = 2,
  parameter int               FILT_LEN    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  output logic [CNT_W-1:0] high_o,
  output logic [CNT_W:0]   period_o,
  output logic             valid_o,
  output logic             timeout_o,
  output logic             ledB,
  output logic             ledR
);

  logic s, rise, fall;

  sig_cond #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_LEN    (FILT_LEN)
  ) u_cond (
    .clk     (clk),
    .rst_n_i (rst),
    .sig_i   (sig_in),
    .s_o     (s),
    .rise_o  (rise),
    .fall_o  (fall)
  );

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   high_len_q, high_len_d;
  logic [CNT_W-1:0]   high_q, high_d;
  logic [CNT_W:0]     period_q, period_d;
  logic               valid_q, valid_d;
  logic               timeout_q, timeout_d;
  logic               led_b_q;

  logic cnt_max, end_high, end_low;

  assign cnt_max  = (cnt_q == TIMEOUT);
  assign end_high = (state_q == ST_HIGH) && fall;
  assign end_low  = (state_q == ST_LOW) && rise;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (rise) state_d = ST_HIGH;
      ST_HIGH: begin
        if (fall)         state_d = ST_LOW;
        else if (cnt_max) state_d = ST_IDLE;
      end
      ST_LOW: begin
        if (rise)         state_d = ST_HIGH;
        else if (cnt_max) state_d = ST_IDLE;
      end
      default:            state_d = ST_IDLE;
    endcase
  end

  // An edge always wins over the timeout, so a phase of exactly TIMEOUT cycles is accepted.
  always_comb begin
    cnt_d      = cnt_q;
    high_len_d = high_len_q;
    high_d     = high_q;
    period_d   = period_q;
    valid_d    = 1'b0;
    timeout_d  = timeout_q;
    if (state_q == ST_IDLE) begin
      cnt_d = rise ? CNT_W'(1) : '0;
    end else if (end_high || end_low) begin
      cnt_d = CNT_W'(1);
      if (end_high) begin
        high_len_d = cnt_q;
      end else begin
        high_d    = high_len_q;
        period_d  = {1'b0, high_len_q} + {1'b0, cnt_q};
        valid_d   = 1'b1;
        timeout_d = 1'b0;
      end
    end else if (cnt_max) begin
      cnt_d     = '0;
      timeout_d = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q      <= '0;
      high_len_q <= '0;
      high_q     <= '0;
      period_q   <= '0;
      valid_q    <= 1'b0;
      timeout_q  <= 1'b0;
      led_b_q    <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      high_len_q <= high_len_d;
      high_q     <= high_d;
      period_q   <= period_d;
      valid_q    <= valid_d;
      timeout_q  <= timeout_d;
      led_b_q    <= s;
    end
  end

  assign high_o    = high_q;
  assign period_o  = period_q;
  assign valid_o   = valid_q;
  assign timeout_o = timeout_q;
  assign ledB      = led_b_q;
  assign ledR      = timeout_q;

endmodule

// File: tb/tb_blink_meter.sv
// Directed bench for blink_meter with TIMEOUT=100, SYNC_STAGES=2, FILT_LEN=4.
module tb_blink_meter;

  localparam int CNT_W = 28;
`ifdef BLINK_METER_FILTER_EN
  localparam int LAT = 3 + 4;
`else
  localparam int LAT = 3;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             sig_in;
  logic [CNT_W-1:0] high_o;
  logic [CNT_W:0]   period_o;
  logic             valid_o, timeout_o, ledB, ledR;

  int ntests = 0;
  int nfail  = 0;
  int nvalid = 0;
  int v0;

  blink_meter #(
    .CNT_W       (CNT_W),
    .TIMEOUT     (28'd100),
    .SYNC_STAGES (2),
    .FILT_LEN    (4)
  ) dut (
    .clk       (clk),
    .rst       (rst_n),
    .sig_in    (sig_in),
    .high_o    (high_o),
    .period_o  (period_o),
    .valid_o   (valid_o),
    .timeout_o (timeout_o),
    .ledB      (ledB),
    .ledR      (ledR)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rst_n && valid_o) nvalid++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic sq(input int h, input int l);
    sig_in = 1'b1;
    repeat (h) tick();
    sig_in = 1'b0;
    repeat (l) tick();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_high"},    32'(high_o), 0);
    chk({tag, "_period"},  32'(period_o), 0);
    chk({tag, "_valid"},   32'(valid_o), 0);
    chk({tag, "_timeout"}, 32'(timeout_o), 0);
    chk({tag, "_ledB"},    32'(ledB), 0);
    chk({tag, "_ledR"},    32'(ledR), 0);
  endtask

  initial begin
    sig_in = 1'b0;
    rst_n  = 1'b0;
    repeat (3) tick();
    chk_zero("reset");
    rst_n = 1'b1;

    // constant low input
    repeat (500) tick();
    chk("idle_novalid", 32'(nvalid), 0);
    chk("idle_timeout", 32'(timeout_o), 0);

    // 10/15 square wave
    v0 = nvalid;
    sq(10, 15);
    chk("wave_first_none", 32'(nvalid - v0), 0);
    sig_in = 1'b1;
    repeat (LAT - 1) tick();
    chk("wave_lat_early", 32'(valid_o), 0);
    tick();
    chk("wave_lat_valid", 32'(valid_o), 1);
    chk("wave_high", 32'(high_o), 10);
    chk("wave_period", 32'(period_o), 25);
    tick();
    chk("wave_strobe_1cyc", 32'(valid_o), 0);
    repeat (10 - LAT - 1) tick();
    sig_in = 1'b0;
    repeat (15) tick();
    sq(10, 15);
    sq(10, 15);
    sig_in = 1'b1;
    repeat (LAT + 1) tick();
    chk("wave_count", 32'(nvalid - v0), 4);
    chk("wave_high2", 32'(high_o), 10);
    chk("wave_period2", 32'(period_o), 25);
    chk("wave_timeout", 32'(timeout_o), 0);
    repeat (10 - LAT - 1) tick();
    sig_in = 1'b0;
    repeat (15) tick();

    // maximum accepted high phase
    sq(100, 20);
    sig_in = 1'b1;
    repeat (LAT) tick();
    chk("max_valid", 32'(valid_o), 1);
    chk("max_high", 32'(high_o), 100);
    chk("max_period", 32'(period_o), 120);

    // held high past the limit
    repeat (99) tick();
    chk("to_before", 32'(timeout_o), 0);
    tick();
    chk("to_flag", 32'(timeout_o), 1);
    chk("to_ledR", 32'(ledR), 1);
    chk("to_ledB", 32'(ledB), 1);
    chk("to_hold_high", 32'(high_o), 100);
    chk("to_hold_period", 32'(period_o), 120);
    sig_in = 1'b0;
    repeat (20) tick();
    v0 = nvalid;
    sq(10, 15);
    chk("to_sticky", 32'(timeout_o), 1);
    chk("to_no_partial", 32'(nvalid - v0), 0);
    sig_in = 1'b1;
    repeat (LAT) tick();
    chk("rec_valid", 32'(valid_o), 1);
    chk("rec_high", 32'(high_o), 10);
    chk("rec_period", 32'(period_o), 25);
    chk("rec_timeout", 32'(timeout_o), 0);
    chk("rec_ledR", 32'(ledR), 0);

    // reset during the low phase
    repeat (10 - LAT) tick();
    sig_in = 1'b0;
    repeat (7) tick();
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (10) tick();
    v0 = nvalid;
    sq(10, 15);
    chk("midrst_no_partial", 32'(nvalid - v0), 0);
    sig_in = 1'b1;
    repeat (LAT) tick();
    chk("midrst_valid", 32'(valid_o), 1);
    chk("midrst_high", 32'(high_o), 10);
    chk("midrst_period", 32'(period_o), 25);

    // 1-cycle glitch inside the low phase
    v0 = nvalid;
    repeat (10 - LAT) tick();
    sig_in = 1'b0;
    repeat (5) tick();
    sig_in = 1'b1;
    tick();
    sig_in = 1'b0;
    repeat (9) tick();
    sig_in = 1'b1;
    repeat (LAT) tick();
    chk("glitch_valid", 32'(valid_o), 1);
`ifdef BLINK_METER_FILTER_EN
    chk("glitch_count", 32'(nvalid - v0), 1);
    chk("glitch_high", 32'(high_o), 10);
    chk("glitch_period", 32'(period_o), 25);

    // 3-cycle pulse suppressed, 4-cycle pulse measured
    repeat (10 - LAT) tick();
    sig_in = 1'b0;
    repeat (5) tick();
    sq(3, 12);
    sig_in = 1'b1;
    repeat (LAT) tick();
    chk("p3_high", 32'(high_o), 10);
    chk("p3_period", 32'(period_o), 30);
    repeat (10 - LAT) tick();
    sig_in = 1'b0;
    repeat (10) tick();
    sq(4, 10);
    sig_in = 1'b1;
    repeat (LAT) tick();
    chk("p4_high", 32'(high_o), 4);
    chk("p4_period", 32'(period_o), 14);
`else
    chk("glitch_count", 32'(nvalid - v0), 2);
    chk("glitch_high", 32'(high_o), 1);
    chk("glitch_period", 32'(period_o), 10);
`endif

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
